// File: rtl/stream_deparser_pkg.sv
// Shared types and helpers for the stream deparser: FSM state encoding and the
// IPv4 header checksum used when a header blob needs its checksum refreshed.
package stream_deparser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCsum,
    StHdr,
    StMerge,
    StFlush,
    StDrop
  } state_e;

  // ip_hdr byte 0 sits in bits [7:0]; words are big-endian; the checksum word reads as zero.
  function automatic logic [15:0] ipv4_csum16(input logic [159:0] ip_hdr);
    logic [19:0] sum;
    sum = '0;
    for (int k = 0; k < 10; k++) begin
      if (k != 5) sum = sum + {4'h0, ip_hdr[16*k +: 8], ip_hdr[16*k+8 +: 8]};
    end
    sum = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
    sum = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
    return ~sum[15:0];
  endfunction

endpackage

// File: rtl/byte_lane_shifter.sv
// Combinational {carry, payload} realignment: r carry bytes land in lanes 0..r-1 and the
// payload follows; the payload bytes pushed past the top lane become the next carry.
module byte_lane_shifter #(
  parameter int unsigned KEEP_WIDTH = 64,
  parameter int unsigned CW         = 8
) (
  input  logic [KEEP_WIDTH*8-1:0] carry_i,
  input  logic [KEEP_WIDTH*8-1:0] payload_i,
  input  logic [CW-1:0]           r_i,
  output logic [KEEP_WIDTH*8-1:0] merged_o,
  output logic [KEEP_WIDTH*8-1:0] carry_o
);

  localparam int unsigned W = KEEP_WIDTH * 8;

  logic [W-1:0] carry_mask;

  always_comb begin
    carry_mask = ~({W{1'b1}} << (32'(r_i) * 8));
    merged_o   = (payload_i << (32'(r_i) * 8)) | (carry_i & carry_mask);
    carry_o    = (r_i == '0) ? '0 : (payload_i >> ((KEEP_WIDTH - 32'(r_i)) * 8));
  end

endmodule

// File: rtl/stream_deparser.sv
// Prepends a header blob (optionally with a refreshed IPv4 checksum) to an AXI-Stream
// payload, realigning the payload behind any partial trailing header beat.
module stream_deparser
  import stream_deparser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned MAX_HDR_BYTES = 128,
  parameter bit          CSUM_EN       = 1'b1,
  parameter int unsigned CSUM_OFFSET   = 14
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [MAX_HDR_BYTES*8-1:0]         hdr_data,
  input  logic [$clog2(MAX_HDR_BYTES+1)-1:0] hdr_len,
  input  logic                               hdr_csum_en,
  input  logic                               hdr_drop,
  input  logic                               hdr_valid,
  output logic                               hdr_ready,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]              s_axis_tkeep,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  output logic                               s_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready
);

  localparam int unsigned HdrW = (MAX_HDR_BYTES * 8 > DATA_WIDTH) ? MAX_HDR_BYTES * 8 : DATA_WIDTH;
  localparam int unsigned CW   = $clog2(2 * KEEP_WIDTH + 1);

  state_e                  state_q;
  // Header blob; while merging, its low lanes hold the carry bytes.
  logic [HdrW-1:0]         hdr_q;
  logic [CW-1:0]           r_q;
  logic [CW-1:0]           flush_q;
  logic [2:0]              hbeats_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [KEEP_WIDTH-1:0]   tkeep_q;
  logic                    tvalid_q;
  logic                    tlast_q;

  logic                    advance;
  logic                    beat_fire;
  logic [CW-1:0]           hdr_r;
  logic [2:0]              hdr_beats;
  logic [CW-1:0]           n_bytes;
  logic [CW-1:0]           total;
  logic [15:0]             csum;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   new_carry;

  function automatic logic [KEEP_WIDTH-1:0] low_ones(input logic [CW-1:0] n);
    logic [KEEP_WIDTH-1:0] m;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  assign advance       = m_axis_tready | ~tvalid_q;
  assign hdr_ready     = aresetn && (state_q == StIdle);
  assign s_axis_tready = (state_q == StMerge) ? advance : (state_q == StDrop);
  assign beat_fire     = s_axis_tvalid & s_axis_tready;

  assign hdr_r     = CW'(32'(hdr_len) % KEEP_WIDTH);
  assign hdr_beats = 3'(32'(hdr_len) / KEEP_WIDTH);
  assign total     = r_q + n_bytes;
  assign csum      = ipv4_csum16(hdr_q[CSUM_OFFSET*8 +: 160]);

  always_comb begin
    n_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n_bytes = n_bytes + CW'(s_axis_tkeep[i]);
  end

  byte_lane_shifter #(
    .KEEP_WIDTH(KEEP_WIDTH),
    .CW        (CW)
  ) u_shifter (
    .carry_i  (hdr_q[DATA_WIDTH-1:0]),
    .payload_i(s_axis_tdata),
    .r_i      (r_q),
    .merged_o (merged),
    .carry_o  (new_carry)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      hdr_q    <= '0;
      r_q      <= '0;
      flush_q  <= '0;
      hbeats_q <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      // An accepted (or empty) output slot drains unless a state below refills it.
      if (advance) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (hdr_valid) begin
            hdr_q    <= HdrW'(hdr_data);
            r_q      <= hdr_r;
            hbeats_q <= hdr_beats;
            if (hdr_drop)                   state_q <= StDrop;
            else if (CSUM_EN && hdr_csum_en) state_q <= StCsum;
            else if (hdr_beats != 3'd0)      state_q <= StHdr;
            else                             state_q <= StMerge;
          end
        end
        StCsum: begin
          hdr_q[(CSUM_OFFSET+10)*8 +: 8] <= csum[15:8];
          hdr_q[(CSUM_OFFSET+11)*8 +: 8] <= csum[7:0];
          state_q <= (hbeats_q != 3'd0) ? StHdr : StMerge;
        end
        StHdr: begin
          if (advance) begin
            tdata_q  <= hdr_q[DATA_WIDTH-1:0];
            tkeep_q  <= '1;
            tvalid_q <= 1'b1;
            hdr_q    <= hdr_q >> DATA_WIDTH;
            hbeats_q <= hbeats_q - 3'd1;
            if (hbeats_q == 3'd1) state_q <= StMerge;
          end
        end
        StMerge: begin
          if (beat_fire) begin
            tdata_q               <= merged;
            tvalid_q              <= 1'b1;
            hdr_q[DATA_WIDTH-1:0] <= new_carry;
            if (s_axis_tlast && (total <= CW'(KEEP_WIDTH))) begin
              tkeep_q <= low_ones(total);
              tlast_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              tkeep_q <= '1;
              if (s_axis_tlast) begin
                flush_q <= total - CW'(KEEP_WIDTH);
                state_q <= StFlush;
              end
            end
          end
        end
        StFlush: begin
          if (advance) begin
            tdata_q  <= hdr_q[DATA_WIDTH-1:0];
            tkeep_q  <= low_ones(flush_q);
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b1;
            state_q  <= StIdle;
          end
        end
        StDrop: begin
          if (beat_fire && s_axis_tlast) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_stream_deparser.sv
// Table-driven bench for stream_deparser (64-bit data, 8 lanes): per-packet byte
// scoreboard, beat/tkeep expectations, checksum model, stall stability and reset cases.
module tb_stream_deparser;

  localparam int unsigned DW = 64;
  localparam int unsigned KB = 8;
  localparam int unsigned MH = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [MH*8-1:0] hdr_data;
  logic [5:0]    hdr_len;
  logic          hdr_csum_en, hdr_drop, hdr_valid, hdr_ready;
  logic [DW-1:0] s_axis_tdata;
  logic [KB-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KB-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;

  stream_deparser #(
    .DATA_WIDTH   (DW),
    .KEEP_WIDTH   (KB),
    .MAX_HDR_BYTES(MH),
    .CSUM_EN      (1'b1),
    .CSUM_OFFSET  (0)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .hdr_data     (hdr_data),
    .hdr_len      (hdr_len),
    .hdr_csum_en  (hdr_csum_en),
    .hdr_drop     (hdr_drop),
    .hdr_valid    (hdr_valid),
    .hdr_ready    (hdr_ready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int         hlen;
    bit         csum;
    bit         drop;
    bit         fixed_ip;
    bit         stall;
    int         pay;
    int         exp_beats;
    logic [7:0] exp_keep;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KB-1:0] keep;
    logic          last;
  } beat_t;

  vec_t        vecs [9];
  logic [7:0]  ip_ref [20];
  logic [7:0]  exp_q [$];
  beat_t       out_q [$];
  int          rd_idx = 0;
  int          checks = 0;
  int          failures = 0;
  bit          stall_mode = 1'b0;

  // Monitor state
  int          valid_cnt = 0;
  int          last_cnt = 0;
  int          stall_viol = 0;
  logic        stalled_q = 1'b0;
  beat_t       held_q;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = stall_mode ? ~m_axis_tready : 1'b1;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      stalled_q <= 1'b0;
    end else begin
      if (stalled_q && (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tlast} != held_q))
        stall_viol <= stall_viol + 1;
      if (m_axis_tvalid) valid_cnt <= valid_cnt + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        if (m_axis_tlast) last_cnt <= last_cnt + 1;
      end
      stalled_q <= m_axis_tvalid && !m_axis_tready;
      held_q    <= {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [7:0] b [32]);
    int unsigned s;
    s = 0;
    for (int k = 0; k < 10; k++) if (k != 5) s += {b[2*k], b[2*k+1]};
    while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
    return 16'(~s);
  endfunction

  task automatic send_hdr(input logic [MH*8-1:0] d, input int len, input bit cs, input bit dr,
                          output bit ok);
    hdr_data    = d;
    hdr_len     = 6'(len);
    hdr_csum_en = cs;
    hdr_drop    = dr;
    hdr_valid   = 1'b1;
    ok          = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      if (hdr_ready) ok = 1'b1;
      tick();
    end
    hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KB-1:0] k, input bit last,
                           output bit ok);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    ok            = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      if (s_axis_tready) ok = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0]      hb [32];
    logic [MH*8-1:0] hd;
    logic [15:0]     c;
    logic [DW-1:0]   d;
    logic [KB-1:0]   k;
    logic [7:0]      gb, eb, g10, g11, lkeep;
    bit              ok, all_ok, done;
    int              nb, n, before_last, before_valid, beats, nmis, got_n;

    stall_mode = v.stall;
    for (int i = 0; i < 32; i++) hb[i] = (v.fixed_ip && i < 20) ? ip_ref[i] : 8'($urandom);
    for (int i = 0; i < 32; i++) hd[8*i +: 8] = hb[i];
    if (v.csum) begin
      c      = model_csum(hb);
      hb[10] = c[15:8];
      hb[11] = c[7:0];
    end
    if (!v.drop) for (int i = 0; i < v.hlen; i++) exp_q.push_back(hb[i]);
    before_last  = last_cnt;
    before_valid = valid_cnt;

    send_hdr(hd, v.hlen, v.csum, v.drop, ok);
    check({tag, "_hdr_accept"}, 64'(ok), 64'd1);

    // First header beat is due one cycle after the handshake, two with the checksum pass.
    if (!v.drop && v.hlen >= 8) begin
      if (v.csum) begin
        tick();
        check({tag, "_csum_latency_gap"}, 64'(m_axis_tvalid), 64'd0);
      end
      tick();
      check({tag, "_first_beat_latency"}, 64'(m_axis_tvalid), 64'd1);
    end

    all_ok = 1'b1;
    nb     = (v.pay + 7) / 8;
    for (int j = 0; j < nb; j++) begin
      n = (v.pay - 8 * j > 8) ? 8 : v.pay - 8 * j;
      for (int b = 0; b < 8; b++) begin
        d[8*b +: 8] = 8'($urandom);
        k[b]        = (b < n);
        if (b < n && !v.drop) exp_q.push_back(d[8*b +: 8]);
      end
      send_beat(d, k, j == nb - 1, ok);
      all_ok &= ok;
    end
    check({tag, "_payload_accept"}, 64'(all_ok), 64'd1);

    if (v.drop) begin
      repeat (4) tick();
      check({tag, "_no_output"}, 64'(valid_cnt - before_valid), 64'd0);
    end else begin
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
        tick();
        if (last_cnt > before_last) done = 1'b1;
      end
      check({tag, "_tlast_seen"}, 64'(done), 64'd1);

      beats = 0; nmis = 0; got_n = 0; g10 = '0; g11 = '0; lkeep = '0;
      for (int e = rd_idx; e < out_q.size(); e++) begin
        beats++;
        for (int l = 0; l < 8; l++) begin
          if (out_q[e].keep[l]) begin
            gb = out_q[e].data[8*l +: 8];
            if (got_n == 10) g10 = gb;
            if (got_n == 11) g11 = gb;
            got_n++;
            if (exp_q.size() == 0) nmis++;
            else begin
              eb = exp_q.pop_front();
              if (gb !== eb) begin
                if (nmis == 0) $display("note: %s byte %0d got %02h want %02h", tag, got_n - 1, gb, eb);
                nmis++;
              end
            end
          end
        end
        lkeep = out_q[e].keep;
      end
      rd_idx = out_q.size();
      check({tag, "_beats"}, 64'(beats), 64'(v.exp_beats));
      check({tag, "_last_tkeep"}, 64'(lkeep), 64'(v.exp_keep));
      check({tag, "_byte_mismatches"}, 64'(nmis), 64'd0);
      check({tag, "_bytes_left"}, 64'(exp_q.size()), 64'd0);
      if (v.fixed_ip) begin
        check({tag, "_csum_hi"}, 64'(g10), 64'h b8);
        check({tag, "_csum_lo"}, 64'(g11), 64'h 61);
      end
      exp_q.delete();
    end
  endtask

  initial begin
    bit ok;

    //          hlen csum drop fixip stall pay beats keep
    vecs[0] = '{14,  1'b0, 1'b0, 1'b0, 1'b0, 28, 6, 8'h03};
    vecs[1] = '{20,  1'b1, 1'b0, 1'b1, 1'b0,  8, 4, 8'h0f};
    vecs[2] = '{0,   1'b0, 1'b0, 1'b0, 1'b0,  4, 1, 8'h0f};
    vecs[3] = '{16,  1'b0, 1'b0, 1'b0, 1'b0, 24, 5, 8'hff};
    vecs[4] = '{16,  1'b0, 1'b0, 1'b0, 1'b1, 24, 5, 8'hff};
    vecs[5] = '{10,  1'b0, 1'b1, 1'b0, 1'b0, 32, 0, 8'h00};
    vecs[6] = '{3,   1'b0, 1'b0, 1'b0, 1'b1, 13, 2, 8'hff};
    vecs[7] = '{27,  1'b1, 1'b0, 1'b0, 1'b0,  1, 4, 8'h0f};
    vecs[8] = '{32,  1'b0, 1'b0, 1'b0, 1'b1, 17, 7, 8'h01};
    ip_ref = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'h5a, 8'ha5, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

    hdr_data = '0; hdr_len = '0; hdr_csum_en = 1'b0; hdr_drop = 1'b0; hdr_valid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    aresetn = 1'b1;
    #3 aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check("reset_hdr_ready", 64'(hdr_ready), 64'd0);
    check("reset_s_tready", 64'(s_axis_tready), 64'd0);
    check("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("reset_m_tdata", m_axis_tdata, 64'd0);
    check("reset_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    check("idle_hdr_ready", 64'(hdr_ready), 64'd1);
    check("idle_s_tready", 64'(s_axis_tready), 64'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while merging: 5-byte header then two non-last payload beats.
    stall_mode = 1'b0;
    repeat (2) tick();
    send_hdr({(MH*8/32){32'hdeadbeef}}, 5, 1'b0, 1'b0, ok);
    check("rst_mid_hdr_accept", 64'(ok), 64'd1);
    send_beat(64'h1122334455667788, 8'hff, 1'b0, ok);
    send_beat(64'h99aabbccddeeff00, 8'hff, 1'b0, ok);
    check("rst_mid_payload_accept", 64'(ok), 64'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst_mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_mid_m_tdata", m_axis_tdata, 64'd0);
    check("rst_mid_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_mid_s_tready", 64'(s_axis_tready), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    exp_q.delete();
    rd_idx = out_q.size();
    run_vec(vecs[0], "post_reset");

    check("stall_stability_violations", 64'(stall_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
